demux256_bit_writer: RTL
========================

Name: demux256_bit_writer

Overview:
- Inverse of the 256-to-1 bit selector: a 1-to-256 bit-addressed writer that assembles a 256-bit word one bit at a time.
- Each accepted beat writes `din` into bit `dout[sel]` and sets the matching bit of a written-mask.
- When every bit has been written, or a flush is requested, the block presents the word to a consumer through a valid/ready handshake.
- Sits upstream of the selector path and builds its `din` vectors.

Parameters:
- N, 256, word width in bits; must equal 2**SEL_W.
- SEL_W, 8, bit-address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  write beat offered.
- in_ready  output  1  block accepts a write beat this cycle.
- din  input  1  bit value to write.
- sel  input  SEL_W  bit index to write, 0..N-1.
- flush  input  1  close the current frame early; ignored unless in FILL with count > 0.
- dout  output  N  assembled word; bit i is the last value written to index i.
- written  output  N  mask of indices written in the current frame.
- count  output  SEL_W+1  number of distinct indices written, 0..N.
- frame_valid  output  1  frame complete and presented.
- frame_ready  input  1  consumer takes the frame.

Behaviour:
- Reset (sync, reset=1 at a rising edge):
  - dout=0, written=0, count=0.
  - State FILL, so in_ready=1 and frame_valid=0.
  - Reset overrides all other inputs and may be asserted mid-frame or in HOLD; the partial frame is discarded.
- States: FILL (in_ready=1, frame_valid=0) and HOLD (in_ready=0, frame_valid=1). Outputs are registered or decoded from state only; no combinational path from inputs to in_ready or frame_valid.
- Accepted write (FILL and in_valid=1):
  - Next edge: dout[sel]<=din, written[sel]<=1.
  - If written[sel] was 0 before the edge, count<=count+1. If it was 1, the value is overwritten and count is unchanged.
- FILL->HOLD, evaluated at the same edge as the write:
  - If the accepted write takes count to N, state<=HOLD. frame_valid is 1 on the cycle after the Nth distinct write; latency is 1 cycle.
  - If flush=1 and (count>0 or a write to a new index is accepted that cycle), state<=HOLD.
  - A write accepted together with flush is included in the frame.
  - flush with count=0 and no accepted write: no effect.
- HOLD:
  - in_valid is ignored; no state change from write beats; dout, written and count are frozen.
  - On frame_valid & frame_ready: next edge written<=0, count<=0, state<=FILL. dout is not cleared; stale bits persist, and the consumer qualifies them with the mask sampled at handover.
  - The first new write can be accepted on the cycle after the handover; there is no back-to-back fill during HOLD.
- frame_ready in FILL is ignored.
- Width rules:
  - count is SEL_W+1 bits and never exceeds N.
  - sel is always in range because 2**SEL_W==N; no out-of-range handling is required.
- Implementation: one always block for state/count/mask, with a per-bit write enable from a decoded sel.

Test Plan:
- Reset then full sweep: write din=sel[0] for sel=0..255, one beat per cycle. Expect frame_valid=1 on the cycle after beat 255, count=256, written=all ones, dout=256'hAAAA…AAAA, in_ready=0.
- Duplicate write: after reset, write sel=5 din=1, then sel=5 din=0. Expect count=1, written=1<<5, dout[5]=0. Then writing the other 255 indices closes the frame at count=256.
- Flush partial: write sel=3 din=1 and sel=200 din=1, then pulse flush. Expect frame_valid=1 next cycle, count=2, written has bits 3 and 200 set. Flush on an empty frame: frame_valid stays 0.
- Backpressure in HOLD: hold frame_ready=0 for 10 cycles while driving in_valid=1 sel=7 din=0. Expect dout/count/written unchanged and in_ready=0. Assert frame_ready=1: next cycle count=0, written=0, in_ready=1, dout still holds the previous frame.
- Write+flush same cycle: with count=4, assert in_valid (sel=9, new index) and flush together. Expect HOLD with count=5 and written[9]=1.
- Reset mid-operation: assert reset after 100 writes, and again while in HOLD. Expect all outputs at reset values the next cycle and in_ready=1.

Source files
------------

// File: rtl/demux256_bit_writer.sv
// 1-to-N bit-addressed writer: builds an N-bit word one bit per beat and hands it off by valid/ready.
// Latency: frame_valid one cycle after the closing write/flush; in HOLD writes are refused (in_ready=0) until frame_ready.
module demux256_bit_writer #(
  parameter int N     = 256,
  parameter int SEL_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  input  logic             flush,
  output logic [N-1:0]     dout,
  output logic [N-1:0]     written,
  output logic [SEL_W:0]   count,
  output logic             frame_valid,
  input  logic             frame_ready
);

  typedef enum logic {S_FILL, S_HOLD} state_t;

  localparam logic [SEL_W:0] LP_FULL = (SEL_W+1)'(N);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_dout;
  logic [N-1:0]     r_written;
  logic [SEL_W:0]   r_count;

  logic             w_accept;
  logic             w_new_idx;
  logic             w_handover;
  logic [N-1:0]     w_wen;
  logic [N-1:0]     w_dout_nxt;
  logic [N-1:0]     w_written_nxt;
  logic [SEL_W:0]   w_count_nxt;

  assign w_accept   = (r_state == S_FILL) && in_valid;
  assign w_new_idx  = w_accept && !r_written[sel];
  assign w_handover = (r_state == S_HOLD) && frame_ready;

  // One-hot write enable decoded from sel; all-zero when no beat is accepted.
  assign w_wen = w_accept ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

  always_comb begin
    w_state_nxt   = r_state;
    w_dout_nxt    = (r_dout & ~w_wen) | (din ? w_wen : '0);
    w_written_nxt = r_written | w_wen;
    w_count_nxt   = r_count + {{SEL_W{1'b0}}, w_new_idx};
    case (r_state)
      S_FILL: begin
        if (w_count_nxt == LP_FULL) begin
          w_state_nxt = S_HOLD;
        end else if (flush && (w_count_nxt != '0)) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_handover) begin
          w_state_nxt   = S_FILL;
          w_written_nxt = '0;
          w_count_nxt   = '0;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FILL;
      r_dout    <= '0;
      r_written <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dout    <= w_dout_nxt;
      r_written <= w_written_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign in_ready    = (r_state == S_FILL);
  assign frame_valid = (r_state == S_HOLD);
  assign dout        = r_dout;
  assign written     = r_written;
  assign count       = r_count;

endmodule
